// File: rtl/risc_prog_loader.sv
// rtl/risc_prog_loader.sv - framed byte stream to instruction-memory write port; optional LOADER_TIMEOUT_EN
module risc_prog_loader #(
    parameter int         ADDR_W         = 7,
    parameter int         DATA_W         = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] inst_address,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_we,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              error
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_cnt;
    logic [7:0]        remaining;
    logic [7:0]        csum;
    logic [7:0]        sum_nx;
    logic              accept;
    logic              timeout_hit;

    assign accept    = in_valid && in_ready;
    assign sum_nx    = csum + in_data;
    assign in_ready  = (state != S_ERR);
    assign error     = (state == S_ERR);
    assign busy      = (state == S_ADDR) || (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign cpu_rst_n = (state == S_DONE);

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || accept || !busy) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = busy && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // without the watchdog a stalled frame waits forever
    assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (accept && in_data == SYNC_BYTE) state_nx = S_ADDR;
            S_ADDR: if (accept) state_nx = in_data[7] ? S_ERR : S_LEN;
            S_LEN: begin
                if (accept) begin
                    if (in_data > 8'd128)      state_nx = S_ERR;
                    else if (in_data == 8'd0)  state_nx = S_CSUM;
                    else                       state_nx = S_DATA;
                end
            end
            S_DATA: if (accept && remaining == 8'd1) state_nx = S_CSUM;
            S_CSUM: if (accept) state_nx = (sum_nx == 8'd0) ? S_DONE : S_ERR;
            S_ERR:  if (err_clr) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (timeout_hit) state_nx = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            addr_cnt     <= '0;
            remaining    <= '0;
            csum         <= '0;
            inst_we      <= 1'b0;
            inst_address <= '0;
            inst_data    <= '0;
        end else begin
            state   <= state_nx;
            inst_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE, S_DONE: if (in_data == SYNC_BYTE) csum <= '0;
                    S_ADDR: begin
                        addr_cnt <= in_data[ADDR_W-1:0];
                        csum     <= sum_nx;
                    end
                    S_LEN: begin
                        remaining <= in_data;
                        csum      <= sum_nx;
                    end
                    // writes commit immediately; a bad checksum only keeps the core in reset
                    S_DATA: begin
                        inst_we      <= 1'b1;
                        inst_address <= addr_cnt;
                        inst_data    <= in_data[DATA_W-1:0];
                        addr_cnt     <= addr_cnt + 1'b1;
                        remaining    <= remaining - 8'd1;
                        csum         <= sum_nx;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
